// File: rtl/vtm_pkg.sv
// Shared constants and the timing tuple type for video_timing_monitor.
package vtm_pkg;
  localparam int HCNT_W_DEF = 12;
  localparam int VCNT_W_DEF = 11;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // One frame's measured raster, in the order it is compared for stability.
  typedef struct packed {
    logic [HCNT_W_DEF-1:0] h_total;
    logic [HCNT_W_DEF-1:0] h_sync;
    logic [HCNT_W_DEF-1:0] h_active;
    logic [VCNT_W_DEF-1:0] v_total;
    logic [VCNT_W_DEF-1:0] v_sync;
    logic [VCNT_W_DEF-1:0] v_active;
    logic [15:0]           crc;
  } vtm_timing_t;
endpackage

// File: rtl/video_timing_monitor_if.sv
// Video input and measurement readout bundle for video_timing_monitor.
// master = video source / readout consumer, slave = the monitor.
interface video_timing_monitor_if #(
  parameter int HCNT_W = vtm_pkg::HCNT_W_DEF,
  parameter int VCNT_W = vtm_pkg::VCNT_W_DEF
);
  logic              ce_pix;
  logic              hs;
  logic              vs;
  logic              de;
  logic [7:0]        r;
  logic [7:0]        g;
  logic [7:0]        b;
  logic [HCNT_W-1:0] h_total;
  logic [HCNT_W-1:0] h_sync;
  logic [HCNT_W-1:0] h_active;
  logic [VCNT_W-1:0] v_total;
  logic [VCNT_W-1:0] v_sync;
  logic [VCNT_W-1:0] v_active;
  logic [15:0]       frame_crc;
  logic              frame_done;
  logic [15:0]       frame_count;
  logic              stable;
  logic              timing_err;

  modport master (
    output ce_pix, hs, vs, de, r, g, b,
    input  h_total, h_sync, h_active, v_total, v_sync, v_active,
    input  frame_crc, frame_done, frame_count, stable, timing_err
  );

  modport slave (
    input  ce_pix, hs, vs, de, r, g, b,
    output h_total, h_sync, h_active, v_total, v_sync, v_active,
    output frame_crc, frame_done, frame_count, stable, timing_err
  );
endinterface

// File: rtl/vtm_crc16_24.sv
// Combinational CRC-16-CCITT step over one 24-bit {r,g,b} pixel, MSB first.
// Only built when VTM_CRC_EN is defined; the default build carries no CRC logic.
`ifdef VTM_CRC_EN
module vtm_crc16_24
  import vtm_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [23:0] data_i,
  output logic [15:0] crc_o
);
  // Bit-serial update unrolled across all 24 data bits.
  always_comb begin
    logic [15:0] c;
    c = crc_i;
    for (int i = 23; i >= 0; i--)
      c = {c[14:0], 1'b0} ^ ((c[15] ^ data_i[i]) ? CRC_POLY : 16'h0000);
    crc_o = c;
  end
endmodule
`endif

// File: rtl/video_timing_monitor.sv
// Raster timing monitor: measures hs/vs/de timing per frame, flags counter
// saturation and reports when the timing has been steady for STABLE_FRAMES.
// Optional feature macro: VTM_CRC_EN adds a CRC-16 over active RGB pixels.
module video_timing_monitor
  import vtm_pkg::*;
#(
  parameter int HCNT_W        = HCNT_W_DEF,
  parameter int VCNT_W        = VCNT_W_DEF,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  video_timing_monitor_if.slave vid
);
  localparam int SC_W = (STABLE_FRAMES < 2) ? 1 : $clog2(STABLE_FRAMES + 1);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_FRAMES);

  typedef struct packed {
    logic [HCNT_W-1:0] h_total;
    logic [HCNT_W-1:0] h_sync;
    logic [HCNT_W-1:0] h_active;
    logic [VCNT_W-1:0] v_total;
    logic [VCNT_W-1:0] v_sync;
    logic [VCNT_W-1:0] v_active;
    logic [15:0]       crc;
  } tuple_t;

  function automatic logic [HCNT_W-1:0] inc_h(input logic [HCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [VCNT_W-1:0] inc_v(input logic [VCNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic              hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d;
  logic              seen_vs_q, seen_vs_d;
  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d, hsw_cnt_q, hsw_cnt_d, de_cnt_q, de_cnt_d;
  logic [HCNT_W-1:0] line_tot_q, line_tot_d, line_sync_q, line_sync_d;
  logic [HCNT_W-1:0] line_act_q, line_act_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d, vsw_cnt_q, vsw_cnt_d, vact_cnt_q, vact_cnt_d;
  tuple_t            out_q, out_d, tup_new;
  logic              frame_done_q, frame_done_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [SC_W-1:0]   stable_cnt_q, stable_cnt_d;
  logic              stable_q, stable_d, err_q, err_d;
  logic              hs_rise, vs_rise;

`ifdef VTM_CRC_EN
  logic [15:0] crc_q, crc_d, crc_nxt;
  vtm_crc16_24 u_crc (.crc_i(crc_q), .data_i({vid.r, vid.g, vid.b}), .crc_o(crc_nxt));
`else
  wire unused_rgb = ^{vid.r, vid.g, vid.b};
`endif

  // Per-pixel measurement and frame close; the hs work of a pixel lands before
  // its vs rise so a coincident line belongs to the frame being closed.
  always_comb begin
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    seen_vs_d     = seen_vs_q;
    h_cnt_d       = h_cnt_q;
    hsw_cnt_d     = hsw_cnt_q;
    de_cnt_d      = de_cnt_q;
    line_tot_d    = line_tot_q;
    line_sync_d   = line_sync_q;
    line_act_d    = line_act_q;
    v_cnt_d       = v_cnt_q;
    vsw_cnt_d     = vsw_cnt_q;
    vact_cnt_d    = vact_cnt_q;
    out_d         = out_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    stable_cnt_d  = stable_cnt_q;
    stable_d      = stable_q;
    err_d         = err_q;
    tup_new       = out_q;
`ifdef VTM_CRC_EN
    crc_d         = crc_q;
`endif
    hs_rise = vid.hs & ~hs_prev_q;
    vs_rise = vid.vs & ~vs_prev_q;

    if (vid.ce_pix) begin
      hs_prev_d = vid.hs;
      vs_prev_d = vid.vs;

      // Line period: the rise pixel starts the next line as pixel 1.
      if (hs_rise) begin
        line_tot_d = h_cnt_q;
        h_cnt_d    = HCNT_W'(1);
      end else begin
        h_cnt_d = inc_h(h_cnt_q);
      end

      // hs pulse width, published when hs drops.
      if (vid.hs) begin
        hsw_cnt_d = inc_h(hsw_cnt_q);
      end else if (hs_prev_q) begin
        line_sync_d = hsw_cnt_q;
        hsw_cnt_d   = '0;
      end

      // Lines are closed on hs rise; only lines with active pixels count.
      if (hs_rise) begin
        if (de_cnt_q != '0) begin
          line_act_d = de_cnt_q;
          vact_cnt_d = inc_v(vact_cnt_q);
        end
        de_cnt_d = vid.de ? HCNT_W'(1) : '0;
        v_cnt_d  = inc_v(v_cnt_q);
        if (vid.vs) vsw_cnt_d = inc_v(vsw_cnt_q);
      end else if (vid.de) begin
        de_cnt_d = inc_h(de_cnt_q);
      end

`ifdef VTM_CRC_EN
      if (vid.de) crc_d = crc_nxt;
`endif

      err_d = err_q | (&h_cnt_d) | (&hsw_cnt_d) | (&de_cnt_d)
                    | (&v_cnt_d) | (&vsw_cnt_d) | (&vact_cnt_d);

      tup_new.h_total  = line_tot_d;
      tup_new.h_sync   = line_sync_d;
      tup_new.h_active = line_act_d;
      tup_new.v_total  = v_cnt_d;
      tup_new.v_sync   = vsw_cnt_d;
      tup_new.v_active = vact_cnt_d;
`ifdef VTM_CRC_EN
      tup_new.crc      = crc_d;
`else
      tup_new.crc      = '0;
`endif

      // The first vs after reset only arms the monitor; its partial frame is dropped.
      if (vs_rise) begin
        if (seen_vs_q) begin
          out_d         = tup_new;
          frame_done_d  = 1'b1;
          frame_count_d = frame_count_q + 16'd1;
          if (tup_new == out_q)
            stable_cnt_d = (stable_cnt_q == SC_MAX) ? SC_MAX : stable_cnt_q + 1'b1;
          else
            stable_cnt_d = SC_W'(1);
          stable_d = (stable_cnt_d == SC_MAX);
        end
        seen_vs_d  = 1'b1;
        v_cnt_d    = '0;
        vsw_cnt_d  = '0;
        vact_cnt_d = '0;
`ifdef VTM_CRC_EN
        crc_d      = CRC_INIT;
`endif
      end
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      seen_vs_q     <= 1'b0;
      h_cnt_q       <= '0;
      hsw_cnt_q     <= '0;
      de_cnt_q      <= '0;
      line_tot_q    <= '0;
      line_sync_q   <= '0;
      line_act_q    <= '0;
      v_cnt_q       <= '0;
      vsw_cnt_q     <= '0;
      vact_cnt_q    <= '0;
      out_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
      stable_cnt_q  <= '0;
      stable_q      <= 1'b0;
      err_q         <= 1'b0;
`ifdef VTM_CRC_EN
      crc_q         <= CRC_INIT;
`endif
    end else begin
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      seen_vs_q     <= seen_vs_d;
      h_cnt_q       <= h_cnt_d;
      hsw_cnt_q     <= hsw_cnt_d;
      de_cnt_q      <= de_cnt_d;
      line_tot_q    <= line_tot_d;
      line_sync_q   <= line_sync_d;
      line_act_q    <= line_act_d;
      v_cnt_q       <= v_cnt_d;
      vsw_cnt_q     <= vsw_cnt_d;
      vact_cnt_q    <= vact_cnt_d;
      out_q         <= out_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
      stable_cnt_q  <= stable_cnt_d;
      stable_q      <= stable_d;
      err_q         <= err_d;
`ifdef VTM_CRC_EN
      crc_q         <= crc_d;
`endif
    end
  end

  assign vid.h_total     = out_q.h_total;
  assign vid.h_sync      = out_q.h_sync;
  assign vid.h_active    = out_q.h_active;
  assign vid.v_total     = out_q.v_total;
  assign vid.v_sync      = out_q.v_sync;
  assign vid.v_active    = out_q.v_active;
  assign vid.frame_done  = frame_done_q;
  assign vid.frame_count = frame_count_q;
  assign vid.stable      = stable_q;
  assign vid.timing_err  = err_q;
`ifdef VTM_CRC_EN
  assign vid.frame_crc   = out_q.crc;
`else
  assign vid.frame_crc   = 16'h0000;
`endif
endmodule

// File: tb/tb_video_timing_monitor.sv
// Directed bench for video_timing_monitor using a scaled-down raster.
// Each table row drives one frame; the frame_done seen at that frame's first
// pixel closes the previous row, so the row's expectations describe that close.
module tb_video_timing_monitor;
  import vtm_pkg::*;

`ifdef VTM_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  typedef struct {
    int htot, hsw, hact, vtot, vsw, vact, flip;
    int done, e_ht, e_hs, e_ha, e_vt, e_vs, e_va, e_stb, e_cnt;
  } vec_t;

  localparam int NV = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  video_timing_monitor_if vif ();
  video_timing_monitor dut (.clk_sys(clk), .reset(rst), .vid(vif));

  int n_chk = 0, n_pass = 0, pulses = 0;
  vtm_timing_t cap;
  logic        cap_stable;
  logic [15:0] cap_count;
  logic [15:0] mdl_crc, prev_crc;
  vec_t        tbl [NV];

  // Snapshot every frame_done high cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (vif.frame_done === 1'b1) begin
      pulses++;
      cap.h_total  = vif.h_total;
      cap.h_sync   = vif.h_sync;
      cap.h_active = vif.h_active;
      cap.v_total  = vif.v_total;
      cap.v_sync   = vif.v_sync;
      cap.v_active = vif.v_active;
      cap.crc      = vif.frame_crc;
      cap_stable   = vif.stable;
      cap_count    = vif.frame_count;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] bt);
    logic [15:0] x;
    x = c ^ {bt, 8'h00};
    for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
    return x;
  endfunction

  task automatic pix(input logic h, input logic v, input logic d, input logic [23:0] rgb);
    @(posedge clk); #1;
    vif.ce_pix = 1'b1; vif.hs = h; vif.vs = v; vif.de = d;
    vif.r = rgb[23:16]; vif.g = rgb[15:8]; vif.b = rgb[7:0];
    @(posedge clk); #1;
    vif.ce_pix = 1'b0;
  endtask

  task automatic drive_frame(input vec_t v, input int nlines);
    logic hh, vv, dd;
    logic [7:0] xb, yb;
    logic [23:0] rgb;
    mdl_crc = 16'hFFFF;
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < v.htot; x++) begin
        hh  = (x < v.hsw);
        vv  = (y < v.vsw);
        dd  = (y >= v.vsw + 1) && (y < v.vsw + 1 + v.vact) &&
              (x >= v.hsw + 2) && (x < v.hsw + 2 + v.hact);
        xb  = 8'(x);
        yb  = 8'(y);
        rgb = {xb, yb, xb ^ 8'h5A};
        if (v.flip != 0 && y == v.vsw + 1 && x == v.hsw + 2) rgb[0] = ~rgb[0];
        if (dd) mdl_crc = crc_byte(crc_byte(crc_byte(mdl_crc, rgb[23:16]), rgb[15:8]), rgb[7:0]);
        pix(hh, vv, dd, rgb);
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int p0;
    logic [15:0] exp_crc;
    exp_crc = (CRC_ON != 0) ? prev_crc : 16'h0000;
    p0 = pulses;
    drive_frame(v, v.vtot);
    chk("pulse_count", pulses - p0, v.done);
    if (v.done != 0) begin
      chk("h_total", cap.h_total, v.e_ht);
      chk("h_sync", cap.h_sync, v.e_hs);
      chk("h_active", cap.h_active, v.e_ha);
      chk("v_total", cap.v_total, v.e_vt);
      chk("v_sync", cap.v_sync, v.e_vs);
      chk("v_active", cap.v_active, v.e_va);
      chk("frame_crc", cap.crc, exp_crc);
      chk("stable", cap_stable, v.e_stb);
      chk("frame_count", cap_count, v.e_cnt);
    end
    prev_crc = mdl_crc;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_h_total"}, vif.h_total, 0);
    chk({tag, "_h_sync"}, vif.h_sync, 0);
    chk({tag, "_h_active"}, vif.h_active, 0);
    chk({tag, "_v_total"}, vif.v_total, 0);
    chk({tag, "_v_sync"}, vif.v_sync, 0);
    chk({tag, "_v_active"}, vif.v_active, 0);
    chk({tag, "_frame_crc"}, vif.frame_crc, 0);
    chk({tag, "_frame_count"}, vif.frame_count, 0);
    chk({tag, "_frame_done"}, vif.frame_done, 0);
    chk({tag, "_stable"}, vif.stable, 0);
    chk({tag, "_timing_err"}, vif.timing_err, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    int ns;
    vec_t pa;
    ns = 1 - CRC_ON;
    // htot hsw hact vtot vsw vact flip | done  e_ht e_hs e_ha e_vt e_vs e_va  stb  cnt
    tbl[0]  = '{20, 3, 12, 12, 2, 8, 0,  0,  0,  0,  0,  0, 0, 0,  0,  0};
    tbl[1]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0,  1};
    tbl[2]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0,  2};
    tbl[3]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  1,  3};
    tbl[4]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  1,  4};
    tbl[5]  = '{21, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  1,  5};
    tbl[6]  = '{20, 3, 12, 12, 2, 8, 0,  1, 21,  3, 12, 12, 2, 8,  0,  6};
    tbl[7]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0,  7};
    tbl[8]  = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0,  8};
    tbl[9]  = '{20, 3, 12, 12, 2, 8, 1,  1, 20,  3, 12, 12, 2, 8,  1,  9};
    tbl[10] = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8, ns, 10};
    tbl[11] = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8, ns, 11};
    tbl[12] = '{24, 5, 10, 14, 3, 6, 0,  1, 20,  3, 12, 12, 2, 8, ns, 12};
    tbl[13] = '{20, 3, 12, 12, 2, 8, 0,  1, 24,  5, 10, 14, 3, 6,  0, 13};
    tbl[14] = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0, 14};
    // rows after the mid-frame reset
    tbl[15] = '{20, 3, 12, 12, 2, 8, 0,  0,  0,  0,  0,  0, 0, 0,  0,  0};
    tbl[16] = '{20, 3, 12, 12, 2, 8, 0,  1, 20,  3, 12, 12, 2, 8,  0,  1};

    vif.ce_pix = 1'b0; vif.hs = 1'b0; vif.vs = 1'b0; vif.de = 1'b0;
    vif.r = '0; vif.g = '0; vif.b = '0;
    prev_crc = 16'hFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (i == 15) begin
        chk("err_clean_raster", vif.timing_err, 0);
        pa = tbl[0];
        drive_frame(pa, 5);
        pulse_reset();
        chk_zero("midrst");
      end
      run_vec(tbl[i]);
    end

    // hs held low long enough to saturate the pixel counter
    chk("err_before_sat", vif.timing_err, 0);
    for (int k = 0; k < 4096; k++) pix(1'b0, 1'b0, 1'b0, 24'h0);
    chk("err_after_sat", vif.timing_err, 1);
    pa = tbl[0];
    drive_frame(pa, pa.vtot);
    chk("err_sticky", vif.timing_err, 1);
    pulse_reset();
    chk("err_cleared_by_reset", vif.timing_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
